// File: rtl/abus_arbiter_if.sv
// a/b request/response bus: one request channel (a) and one in-order response channel (b).
// "master" drives requests and receives responses; "slave" accepts requests and returns responses.
interface abus_arbiter_if;
  logic        avalid;
  logic        aready;
  logic        awe;
  logic [29:0] aaddr;
  logic [31:0] adata;
  logic [3:0]  astrb;
  logic        bvalid;
  logic [31:0] bdata;

  modport master (output avalid, awe, aaddr, adata, astrb, input aready, bvalid, bdata);
  modport slave  (input avalid, awe, aaddr, adata, astrb, output aready, bvalid, bdata);
endinterface

// File: rtl/abus_arbiter.sv
// Two-master round-robin arbiter onto one a/b slave port; an in-order ID FIFO
// remembers who owns each outstanding request so responses route back correctly.
module abus_arbiter #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  abus_arbiter_if.slave  m0,
  abus_arbiter_if.slave  m1,
  abus_arbiter_if.master s,
  output logic           err_spurious
);

  typedef enum logic { ARB_FREE, ARB_LOCKED } arb_state_t;

  arb_state_t            state;
  logic                  locked_id;
  logic                  last_grant;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0]      id_fifo;

  logic grant, can_issue, acc, pop, head;

  // A stalled request keeps the bus: the slave must never see the payload change.
  always_comb begin
    grant = 1'b0;
    if (state == ARB_LOCKED)       grant = locked_id;
    else if (m0.avalid && m1.avalid) grant = ~last_grant;
    else if (m1.avalid)            grant = 1'b1;
  end

  // Only the registered count gates issue; a same-cycle pop does not free a slot.
  assign can_issue = (count < (DEPTH_LOG2+1)'(DEPTH));

  assign s.avalid = can_issue && (grant ? m1.avalid : m0.avalid);
  assign s.awe    = grant ? m1.awe   : m0.awe;
  assign s.aaddr  = grant ? m1.aaddr : m0.aaddr;
  assign s.adata  = grant ? m1.adata : m0.adata;
  assign s.astrb  = grant ? m1.astrb : m0.astrb;

  assign acc  = s.avalid && s.aready;
  assign pop  = s.bvalid && (count != '0);
  assign head = id_fifo[rd_ptr];

  assign m0.aready = acc && !grant;
  assign m1.aready = acc &&  grant;
  assign m0.bvalid = pop && !head;
  assign m1.bvalid = pop &&  head;
  assign m0.bdata  = s.bdata;
  assign m1.bdata  = s.bdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_FREE;
      locked_id    <= 1'b0;
      last_grant   <= 1'b1;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      id_fifo      <= '0;
      err_spurious <= 1'b0;
    end else begin
      case (state)
        ARB_FREE:
          if (s.avalid && !s.aready) begin
            state     <= ARB_LOCKED;
            locked_id <= grant;
          end
        ARB_LOCKED:
          if (acc) state <= ARB_FREE;
        default: state <= ARB_FREE;
      endcase

      if (acc) begin
        id_fifo[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + 1'b1;
        last_grant      <= grant;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      // A response with nothing outstanding is a slave protocol error; the FIFO is left alone.
      if (s.bvalid && count == '0) err_spurious <= 1'b1;

      case ({acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
